afifo_rstream: RTL and testbench
================================

# afifo_rstream

Synthesizable read-side consumer of the async FIFO, in the read clock domain directly downstream of the FIFO read port. It pops words by driving `rinc` against `rempty`/`rdata` and re-presents them as a valid/ready stream through a 2-entry prefetch buffer. This gives full throughput with a registered `m_data`/`m_valid` and absorbs consumer back-pressure without dropping words.

## Interface
- `DATA_WIDTH`, 32, FIFO word and stream data width
- `CNT_WIDTH`, 16, width of statistics counters

- `rclk`  in  1  read-domain clock
- `rrst`  in  1  reset; synchronous, active-high
- `rempty`  in  1  FIFO empty flag; rdata is valid whenever low (first-word-fall-through)
- `rdata`  in  DATA_WIDTH  FIFO head word
- `rinc`  out  1  pop strobe; FIFO advances on `rclk` edge while high
- `flush`  in  1  synchronous buffer clear
- `m_valid`  out  1  stream word valid
- `m_ready`  in  1  consumer accepts
- `m_data`  out  DATA_WIDTH  stream word
- `pop_cnt`  out  CNT_WIDTH  words popped from FIFO
- `stall_cnt`  out  CNT_WIDTH  starved cycles

## Operation
- Occupancy FSM: `EMPTY` (0), `ONE` (1), `TWO` (2); `m_valid = (state != EMPTY)`; `m_data` = oldest entry.
- Pop: `rinc = !rrst && !flush && !rempty && (state != TWO || m_ready)`. On the edge with `rinc`, `rdata` is written to the buffer tail.
- Transitions (push = rinc, pop = m_valid && m_ready):
  - EMPTY: push → ONE; else stay.
  - ONE: push&pop → ONE (head replaced by rdata); push only → TWO; pop only → EMPTY.
  - TWO: push&pop → TWO (entry 1 shifts to head, rdata to tail); pop only → ONE; push without pop is impossible.
- `m_ready` is ignored in EMPTY.
- Flush: next state EMPTY, buffered words discarded. `rinc` is held low during flush, so no FIFO word is lost. A `m_valid && m_ready` in the flush cycle counts as a completed transfer.
- `pop_cnt`: +1 per `rinc` cycle, saturating at all-ones.
- `stall_cnt`: +1 per cycle with `state == EMPTY && rempty && m_ready`, saturating.
- Counters are cleared by `rrst` only, not by `flush`.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, state EMPTY, `pop_cnt`=0, `stall_cnt`=0, `rinc`=0 (gated combinationally by `rrst`).
- Latency: FIFO word at head with `rempty`=0 in cycle N, state EMPTY → `rinc`=1 in N, `m_valid`=1 with that word in N+1.
- Throughput: 1 word/cycle sustained when `m_ready`=1 and FIFO non-empty.
- Handshake: while `m_valid && !m_ready`, `m_valid` and `m_data` are held stable. `m_valid` never drops without a pop, flush or reset.
- `m_valid`, `m_data` and counters are registered. `rinc` is combinational from `rempty`, `m_ready`, `flush`, `rrst`, state.
- Reset mid-operation: state returns to EMPTY on the next edge. Buffered words are discarded and are not returned to the FIFO.
- Ordering: words leave `m_data` in strict FIFO pop order.

## Configuration
- `AFIFO_RSTREAM_STATS_EN` defined: `pop_cnt`/`stall_cnt` counters implemented as above.
- Not defined: counter registers omitted, `pop_cnt`/`stall_cnt` tied to 0. Ports remain present, and the data path is cycle-identical.

## Structure
- `afifo_pkg`:
  - `typedef enum logic [1:0] {RS_EMPTY, RS_ONE, RS_TWO} afifo_rstream_state_e`
  - `localparam int AFIFO_RSTREAM_DEPTH = 2`
- Sub-module `afifo_rstream_buf`: the 2-entry shift buffer. Inputs are push, pop, flush and write data; outputs are head data and state. The top level holds the `rinc` logic and counters.

## Test plan
- Reset: assert `rrst` 3 cycles with `rempty`=0, `rdata`=32'hA5A5_0001 → `rinc`=0, `m_valid`=0, `m_data`=0, counters 0 throughout.
- Streaming: FIFO holds 0x10..0x17, `m_ready`=1 → `m_data` = 0x10..0x17 on 8 consecutive cycles starting 1 cycle after the first `rinc`; `pop_cnt`=8.
- Back-pressure: 4 words queued (0x20..0x23), `m_ready`=0 for 5 cycles → `rinc` high exactly 2 cycles, state TWO, `m_data`=0x20 held stable. Then `m_ready`=1 → 0x20, 0x21, 0x22, 0x23 in order, no gaps.
- Simultaneous push/pop in TWO: `rempty`=0, `m_ready`=1 → state stays TWO, one word in and one out per cycle, `rinc` high every cycle.
- Flush: state TWO holding 0x30, 0x31, FIFO head 0x32, `flush`=1 for 1 cycle → `rinc`=0 that cycle, `m_valid`=0 next cycle, then the next word out is 0x32.
- Starvation with `AFIFO_RSTREAM_STATS_EN`: `rempty`=1, `m_ready`=1 for 10 cycles → `stall_cnt`=10. Same stimulus without the macro → `stall_cnt`=0.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO read-side stream adapter.
package afifo_pkg;

  typedef enum logic [1:0] {
    RS_EMPTY,
    RS_ONE,
    RS_TWO
  } afifo_rstream_state_e;

  localparam int AFIFO_RSTREAM_DEPTH = 2;

endpackage

// File: rtl/afifo_rstream_buf.sv
// Two-entry prefetch shift buffer: entry 0 is the head presented downstream,
// entry 1 holds the word prefetched while the consumer is stalled.
module afifo_rstream_buf
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output afifo_rstream_state_e state
);

  logic [DATA_WIDTH-1:0] ent [AFIFO_RSTREAM_DEPTH];

  // NOTE: all state here is updated with non-blocking assignments so the
  // entry shift (ent[0] <= ent[1]) reads the pre-edge value of ent[1].
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RS_EMPTY;
      // NOTE: the entries are reset as well because entry 0 drives m_data,
      // which must read zero out of reset.
      ent[0] <= '0;
      ent[1] <= '0;
    end else if (flush) begin
      state <= RS_EMPTY;
    end else begin
      case (state)
        RS_EMPTY: begin
          if (push) begin
            ent[0] <= wdata;
            state  <= RS_ONE;
          end
        end
        RS_ONE: begin
          if (push && pop) begin
            ent[0] <= wdata;
          end else if (push) begin
            ent[1] <= wdata;
            state  <= RS_TWO;
          end else if (pop) begin
            state <= RS_EMPTY;
          end
        end
        RS_TWO: begin
          // Push without pop cannot occur here: rinc is held low when full.
          if (pop) begin
            ent[0] <= ent[1];
            if (push) ent[1] <= wdata;
            else      state  <= RS_ONE;
          end
        end
        default: state <= RS_EMPTY;
      endcase
    end
  end

  assign head = ent[0];

endmodule

// File: rtl/afifo_rstream.sv
// Read-domain async FIFO consumer re-presenting words as a valid/ready stream.
// Optional statistics counters are enabled by defining AFIFO_RSTREAM_STATS_EN.
module afifo_rstream
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  pop_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  afifo_rstream_state_e state;
  logic                 pop;

  assign m_valid = (state != RS_EMPTY);
  assign pop     = m_valid && m_ready;
  // Pop from the FIFO only when the buffer has room after this cycle's transfer.
  assign rinc    = !rrst && !flush && !rempty && ((state != RS_TWO) || m_ready);

  afifo_rstream_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (rclk),
    .rst  (rrst),
    .push (rinc),
    .pop  (pop),
    .flush(flush),
    .wdata(rdata),
    .head (m_data),
    .state(state)
  );

`ifdef AFIFO_RSTREAM_STATS_EN
  logic [CNT_WIDTH-1:0] pop_q;
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      pop_q   <= '0;
      stall_q <= '0;
    end else begin
      if (rinc && (pop_q != '1))
        pop_q <= pop_q + CNT_WIDTH'(1);
      if ((state == RS_EMPTY) && rempty && m_ready && (stall_q != '1))
        stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign pop_cnt   = pop_q;
  assign stall_cnt = stall_q;
`else
  assign pop_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_afifo_rstream.sv
// Directed bench for afifo_rstream with a behavioural FWFT FIFO and a
// scoreboard monitor checking every stream transfer against expected words.
`timescale 1ns/1ps
module tb_afifo_rstream;
  import afifo_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
`ifdef AFIFO_RSTREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 rclk = ~rclk;

  afifo_rstream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .pop_cnt  (pop_cnt),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic upd();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic load(input logic [DW-1:0] w, input bit expect_out);
    fifo_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  // Drive point: 2 time units after the rising edge.
  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  // Sample point: falling edge.
  task automatic smp();
    @(negedge rclk);
  endtask

  // FWFT FIFO model: head advances on every edge with rinc high.
  always @(posedge rclk) begin
    if (rinc) begin
      check("rinc_while_empty", rempty, 1'b0);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    #1 upd();
  end

  // Scoreboard monitor: each accepted stream word must match the oldest expectation.
  always @(negedge rclk) begin
    if (!rrst && m_valid && m_ready) begin
      check("stream_word_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("stream_word", m_data, exp_q.pop_front());
    end
  end

  initial begin
    int rinc_hi;

    // Reset with a word sitting at the FIFO head.
    rrst    = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    fifo_q.push_back(32'hA5A5_0001);
    upd();
    repeat (3) begin
      smp();
      check("rst_rinc", rinc, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, 32'h0);
      check("rst_pop_cnt", pop_cnt, 16'h0);
      check("rst_stall_cnt", stall_cnt, 16'h0);
    end
    step();
    fifo_q.delete();
    rrst = 1'b0;
    upd();

    // Streaming 0x10..0x17 at full rate.
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) load(DW'(32'h10 + i), 1'b1);
    upd();
    smp();
    check("stream_first_rinc", rinc, 1'b1);
    check("stream_first_valid", m_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      smp();
      check("stream_valid", m_valid, 1'b1);
      check("stream_data", m_data, DW'(32'h10 + i));
    end
    step();
    m_ready = 1'b0;
    smp();
    check("stream_drained", m_valid, 1'b0);
    check("stream_pop_cnt", pop_cnt, STATS ? 16'd8 : 16'd0);

    // Back-pressure: 4 words queued, consumer stalled for 5 cycles.
    step();
    for (int i = 0; i < 4; i++) load(DW'(32'h20 + i), 1'b1);
    upd();
    rinc_hi = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      rinc_hi += int'(rinc);
      check("bp_valid", m_valid, (i >= 1));
      if (i >= 1) check("bp_data_held", m_data, 32'h20);
      if (i >= 2) check("bp_state_two", dut.state, RS_TWO);
    end
    check("bp_rinc_cycles", rinc_hi, 2);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      check("bp_release_valid", m_valid, 1'b1);
      check("bp_release_data", m_data, DW'(32'h20 + i));
    end
    step();
    m_ready = 1'b0;

    // Simultaneous push and pop while full.
    step();
    for (int i = 0; i < 8; i++) load(DW'(32'h40 + i), 1'b1);
    upd();
    repeat (3) smp();
    check("pp_fill_two", dut.state, RS_TWO);
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      smp();
      check("pp_rinc", rinc, 1'b1);
      check("pp_state", dut.state, RS_TWO);
      check("pp_data", m_data, DW'(32'h40 + i));
    end
    smp();
    check("pp_tail0", m_data, 32'h46);
    smp();
    check("pp_tail1", m_data, 32'h47);
    step();
    m_ready = 1'b0;

    // Flush while full; the head transfer in the flush cycle completes.
    step();
    load(32'h30, 1'b1);
    load(32'h31, 1'b0);
    load(32'h32, 1'b1);
    upd();
    repeat (3) smp();
    check("fl_state_two", dut.state, RS_TWO);
    check("fl_head", m_data, 32'h30);
    step();
    flush   = 1'b1;
    m_ready = 1'b1;
    smp();
    check("fl_rinc_low", rinc, 1'b0);
    step();
    flush   = 1'b0;
    m_ready = 1'b0;
    smp();
    check("fl_valid_cleared", m_valid, 1'b0);
    step();
    m_ready = 1'b1;
    smp();
    check("fl_next_valid", m_valid, 1'b1);
    check("fl_next_data", m_data, 32'h32);
    step();
    m_ready = 1'b0;
    smp();
    check("fl_pop_cnt_kept", pop_cnt, STATS ? 16'd23 : 16'd0);

    // Starvation: empty FIFO, consumer ready for 10 edges.
    step();
    m_ready = 1'b1;
    repeat (10) step();
    m_ready = 1'b0;
    smp();
    check("starve_stall_cnt", stall_cnt, STATS ? 16'd10 : 16'd0);
    check("starve_valid", m_valid, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    check("fifo_model_empty", fifo_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
